// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Imported by the interface, the scoreboard and the top.
package regfile_wb_arbiter_pkg;

  localparam int REG_IDX_W  = 4;
  localparam int NUM_REGS   = 16;
  // Wide enough for the largest allowed MAX_WAIT (15).
  localparam int WAIT_CNT_W = 4;

  typedef enum logic {
    ARB_NORMAL,
    ARB_HOLD
  } arb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writer A (pipeline writeback) and writer B (long-latency result) bus.
// The master drives the requests; the arbiter is the slave.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DBITS = 32
);

  logic                 a_valid;
  logic [REG_IDX_W-1:0] a_rd;
  logic [DBITS-1:0]     a_data;
  logic                 a_hold;
  logic                 b_valid;
  logic                 b_ready;
  logic [REG_IDX_W-1:0] b_rd;
  logic [DBITS-1:0]     b_data;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_hold, b_ready
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_hold, b_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Busy scoreboard for registers awaiting a long-latency result.
// Drives the reservation handshake and the decode hazard flag.
module regfile_wb_arbiter_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rd,
  output logic                 iss_ready,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_rd,
  input  logic                 chk_en,
  input  logic [REG_IDX_W-1:0] chk_rs1,
  input  logic [REG_IDX_W-1:0] chk_rs2,
  input  logic [REG_IDX_W-1:0] chk_rd,
  output logic                 hazard,
  output logic [NUM_REGS-1:0]  busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  assign busy      = busy_q;
  assign iss_ready = !busy_q[iss_rd];
  assign hazard    = chk_en && (busy_q[chk_rs1] || busy_q[chk_rs2] || busy_q[chk_rd]);

  // Set is applied after clear so a same-index reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en)
      busy_d[clr_rd] = 1'b0;
    if (iss_valid && iss_ready)
      busy_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the pipeline (A)
// and the long-latency result path (B), forcing a pipeline hold if B starves.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DBITS    = 32,
  parameter int MAX_WAIT = 4
)(
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rd,
  output logic                 iss_ready,
  input  logic [REG_IDX_W-1:0] chk_rs1,
  input  logic [REG_IDX_W-1:0] chk_rs2,
  input  logic [REG_IDX_W-1:0] chk_rd,
  input  logic                 chk_en,
  output logic                 hazard,
  output logic [NUM_REGS-1:0]  busy,
  output logic                 rf_wrtEn,
  output logic [REG_IDX_W-1:0] rf_rd,
  output logic [DBITS-1:0]     rf_data,
  output logic                 protocol_err
);

  arb_state_t            state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic                  a_hold, b_ready_arb, b_ready;
  logic                  grant_a, grant_b;

  assign bus.a_hold  = a_hold;
  assign bus.b_ready = b_ready;
  // B is never accepted during reset so an in-flight result is dropped.
  assign b_ready = b_ready_arb && !reset;
  assign grant_b = bus.b_valid && b_ready;

  always_comb begin
    state_d     = state_q;
    a_hold      = 1'b0;
    b_ready_arb = 1'b0;
    grant_a     = 1'b0;
    case (state_q)
      ARB_NORMAL: begin
        b_ready_arb = !bus.a_valid;
        grant_a     = bus.a_valid;
        if (bus.b_valid && bus.a_valid && wait_q == WAIT_CNT_W'(MAX_WAIT - 1))
          state_d = ARB_HOLD;
      end
      ARB_HOLD: begin
        a_hold      = 1'b1;
        b_ready_arb = 1'b1;
        state_d     = ARB_NORMAL;
      end
      default: state_d = ARB_NORMAL;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (!bus.b_valid || grant_b)
      wait_d = '0;
    else if (wait_q < WAIT_CNT_W'(MAX_WAIT))
      wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_NORMAL;
      wait_q       <= '0;
      protocol_err <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == ARB_HOLD && bus.a_valid)
        protocol_err <= 1'b1;
    end
  end

  // Registered write port; index and data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wrtEn <= 1'b0;
      rf_rd    <= '0;
      rf_data  <= '0;
    end else if (grant_a) begin
      rf_wrtEn <= 1'b1;
      rf_rd    <= bus.a_rd;
      rf_data  <= bus.a_data;
    end else if (grant_b) begin
      rf_wrtEn <= 1'b1;
      rf_rd    <= bus.b_rd;
      rf_data  <= bus.b_data;
    end else begin
      rf_wrtEn <= 1'b0;
    end
  end

  regfile_wb_arbiter_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .clr_en    (grant_b),
    .clr_rd    (bus.b_rd),
    .chk_en    (chk_en),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .chk_rd    (chk_rd),
    .hazard    (hazard),
    .busy      (busy)
  );

endmodule
